clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Run-time controller for a toggle-style programmable clock divider. It owns the divide counter and output flop, and accepts new divide ratios over a valid/ready handshake. Ratio changes and stop requests take effect only at a full-period boundary, so the output never shows a runt pulse. It sits between a configuration master (register block or sequencer) and logic that consumes a divided clock or enable tick.

## Interface
- BITS, 8: width of the divide counter and of cfg_div.
- DEFAULT_DIV, 16: ratio loaded at reset; out toggles every DIV clk cycles, so the out period is 2*DIV cycles.

- clk  input  1  single system clock; all logic runs on the posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  level; high requests running, low requests a clean stop.
- cfg_valid  input  1  a new ratio is offered on cfg_div.
- cfg_div  input  BITS  requested ratio; 0 is illegal.
- cfg_ready  output  1  the controller can accept a ratio this cycle.
- cfg_err  output  1  one-cycle pulse when cfg_div==0 is offered with cfg_valid.
- out  output  1  divided output, registered.
- tick  output  1  one-cycle pulse, registered, asserted in the cycle after every out toggle.
- busy  output  1  high in RUN, PEND and STOP.

## Operation
- Registers: state, count[BITS-1:0], active_div, pending_div, out, tick, cfg_err.
- Reset values:
  - state=IDLE, count=0, active_div=DEFAULT_DIV, pending_div=DEFAULT_DIV.
  - out=0, tick=0, cfg_err=0, cfg_ready=1, busy=0.
- cfg_ready is combinational: 1 in IDLE and RUN, 0 in PEND and STOP.
- A handshake occurs when cfg_valid && cfg_ready.
- A handshake with cfg_div==0 gives a cfg_err pulse on the next cycle. The value is discarded and state is unchanged.
- Terminal count (TC) is count==active_div-1 in RUN, PEND or STOP.
  - At TC: count<=0, out<=~out, tick<=1.
  - Otherwise: count<=count+1, tick<=0.
- The fall point (FP) is a TC while out==1, i.e. the end of a full period.

States:
- IDLE
  - count and out are held at 0.
  - A legal handshake sets active_div<=cfg_div immediately.
  - enable==1 moves to RUN.
  - If enable rises and a legal handshake occurs in the same cycle, the new ratio is used from the first period.
- RUN
  - Counts and toggles.
  - A legal handshake stores pending_div and moves to PEND.
  - enable==0 moves to STOP.
  - If both happen in the same cycle, go to STOP with the pending ratio stored; it is applied at the FP.
- PEND
  - Counts with the old ratio.
  - At FP: active_div<=pending_div, out<=0, count<=0, then move to RUN, or to IDLE if enable==0.
  - enable==0 before the FP moves to STOP and keeps the pending ratio.
- STOP
  - Counts with the old ratio.
  - At FP: apply any pending ratio, out<=0, count<=0, move to IDLE.
  - enable re-asserted before the FP returns to RUN, or to PEND if a ratio is pending. There is no glitch; counting is uninterrupted.
- rst asserted in any state, including mid-period, forces the reset values on the next edge. Any pending ratio is dropped.

Arithmetic:
- count and the comparison are BITS wide; active_div-1 never underflows because 0 is rejected.
- cfg_div = 2^BITS-1 is legal.
- Ratio 1 toggles out on every edge.

## Timing
- With enable sampled high at edge E in IDLE:
  - count=0 after E.
  - out first rises after edge E+active_div and falls after E+2*active_div.
- tick is high in exactly the cycle following each out change.
- Ratio latency: a new ratio is applied only at the next FP after acceptance, never mid-period. The worst case is 2*old_div cycles.
- cfg_err is high for exactly one cycle, one cycle after the offending handshake.
- Stop latency: out is 0 and state is IDLE no later than the first FP after enable falls.
- Throughput: one ratio change per output period.

## Test plan
- Reset then enable=1, DEFAULT_DIV=16 -> out rises at cycle 16 and falls at cycle 32; period 32; tick pulses every 16 cycles; busy=1.
- IDLE handshake cfg_div=3, then enable -> out period 6; cfg_ready=1 throughout.
- Running div=4, handshake cfg_div=2 with out high mid-period -> cfg_ready=0 until the FP, then period 4 with no pulse shorter than 2 cycles.
- cfg_valid with cfg_div=0 in RUN -> cfg_err high for one cycle; ratio and state unchanged.
- enable drop mid-high-phase at div=5 -> out completes its high phase, falls at the FP; IDLE, busy=0, count=0. Re-enable inside STOP -> continuous waveform.
- rst pulse mid-period in PEND -> next cycle out=0, count=0, active_div=16, pending ratio lost; cfg_div=1 then enable -> out toggles every cycle.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Ratio-configuration handshake between a config master and clk_div_ctrl.
// A transfer happens on any cycle with cfg_valid && cfg_ready.
interface clk_div_ctrl_if #(
    parameter int unsigned BITS = 8
) ();
    logic            cfg_valid;
    logic [BITS-1:0] cfg_div;
    logic            cfg_ready;
    logic            cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Toggle-style programmable clock divider controller. Ratio changes and stops are deferred to
// the fall point (end of a full output period), so out never shows a runt pulse.
module clk_div_ctrl #(
    parameter int unsigned BITS        = 8,
    parameter int unsigned DEFAULT_DIV = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    clk_div_ctrl_if.slave  cfg,
    output logic           out,
    output logic           tick,
    output logic           busy
);

    localparam logic [BITS-1:0] DefDiv = BITS'(DEFAULT_DIV);

    typedef enum logic [1:0] {StIdle, StRun, StPend, StStop} state_e;

    state_e          state_q;
    logic [BITS-1:0] count_q;
    logic [BITS-1:0] active_div_q;
    logic [BITS-1:0] pending_div_q;
    logic            pend_q;
    logic            out_q;
    logic            tick_q;
    logic            cfg_err_q;

    logic            ready;
    logic            hs;
    logic            hs_ok;
    logic            tc;
    logic            fp;
    logic [BITS-1:0] count_step;

    always_comb begin
        ready = (state_q == StIdle) || (state_q == StRun);
        hs    = cfg.cfg_valid && ready;
        hs_ok = hs && (cfg.cfg_div != '0);
        // Only meaningful while counting; IDLE ignores it.
        tc    = (count_q == active_div_q - 1'b1);
        fp    = tc && out_q;
        count_step = tc ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            count_q       <= '0;
            active_div_q  <= DefDiv;
            pending_div_q <= DefDiv;
            pend_q        <= 1'b0;
            out_q         <= 1'b0;
            tick_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            cfg_err_q <= hs && (cfg.cfg_div == '0);
            unique case (state_q)
                StIdle: begin
                    count_q <= '0;
                    out_q   <= 1'b0;
                    tick_q  <= 1'b0;
                    if (hs_ok) begin
                        active_div_q <= cfg.cfg_div;
                    end
                    if (enable) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    count_q <= count_step;
                    out_q   <= out_q ^ tc;
                    tick_q  <= tc;
                    if (hs_ok) begin
                        pending_div_q <= cfg.cfg_div;
                        pend_q        <= 1'b1;
                        state_q       <= enable ? StPend : StStop;
                    end else if (!enable) begin
                        state_q <= StStop;
                    end
                end
                StPend: begin
                    count_q <= count_step;
                    out_q   <= out_q ^ tc;
                    tick_q  <= tc;
                    if (fp) begin
                        active_div_q <= pending_div_q;
                        pend_q       <= 1'b0;
                        state_q      <= enable ? StRun : StIdle;
                    end else if (!enable) begin
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    count_q <= count_step;
                    out_q   <= out_q ^ tc;
                    tick_q  <= tc;
                    if (fp) begin
                        if (pend_q) begin
                            active_div_q <= pending_div_q;
                        end
                        pend_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (enable) begin
                        // Resume without interrupting the count.
                        state_q <= pend_q ? StPend : StRun;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cfg.cfg_ready = ready;
    assign cfg.cfg_err   = cfg_err_q;
    assign out           = out_q;
    assign tick          = tick_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: a cycle table for small ratios plus hand sequences for
// default-ratio timing, stop/resume and reset during a pending ratio change.
module tb_clk_div_ctrl;

    localparam int unsigned BITS        = 8;
    localparam int unsigned DEFAULT_DIV = 16;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic out;
    logic tick;
    logic busy;

    clk_div_ctrl_if #(.BITS(BITS)) cfg ();

    clk_div_ctrl #(
        .BITS        (BITS),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .cfg    (cfg.slave),
        .out    (out),
        .tick   (tick),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // in = {rst, enable, cfg_valid}; exp = {out, tick, busy, cfg_ready, cfg_err} after the edge
    typedef struct packed {
        logic [2:0] in;
        logic [7:0] div;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [2:0] in, input logic [7:0] div, input logic [4:0] exp);
        vec_t v;
        v.in  = in;
        v.div = div;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_div   = '0;

        // Reset, IDLE ratio 3, run, div=0 error, change to 2 mid-high, stop, ratio 1 with enable
        add(3'b100, 8'd0, 5'b00010);
        add(3'b001, 8'd3, 5'b00010);
        add(3'b010, 8'd0, 5'b00110);
        add(3'b010, 8'd0, 5'b00110);
        add(3'b010, 8'd0, 5'b00110);
        add(3'b010, 8'd0, 5'b11110);
        add(3'b010, 8'd0, 5'b10110);
        add(3'b010, 8'd0, 5'b10110);
        add(3'b010, 8'd0, 5'b01110);
        add(3'b011, 8'd0, 5'b00111);
        add(3'b010, 8'd0, 5'b00110);
        add(3'b010, 8'd0, 5'b11110);
        add(3'b011, 8'd2, 5'b10100);
        add(3'b011, 8'd7, 5'b10100);
        add(3'b010, 8'd0, 5'b01110);
        add(3'b010, 8'd0, 5'b00110);
        add(3'b010, 8'd0, 5'b11110);
        add(3'b010, 8'd0, 5'b10110);
        add(3'b010, 8'd0, 5'b01110);
        add(3'b010, 8'd0, 5'b00110);
        add(3'b010, 8'd0, 5'b11110);
        add(3'b000, 8'd0, 5'b10100);
        add(3'b000, 8'd0, 5'b01010);
        add(3'b000, 8'd0, 5'b00010);
        add(3'b011, 8'd1, 5'b00110);
        add(3'b010, 8'd0, 5'b11110);
        add(3'b010, 8'd0, 5'b01110);
        add(3'b010, 8'd0, 5'b11110);

        #2;
        foreach (vecs[i]) begin
            rst           = vecs[i].in[2];
            enable        = vecs[i].in[1];
            cfg.cfg_valid = vecs[i].in[0];
            cfg.cfg_div   = vecs[i].div;
            step();
            check($sformatf("vec%0d.out", i),   out,           vecs[i].exp[4]);
            check($sformatf("vec%0d.tick", i),  tick,          vecs[i].exp[3]);
            check($sformatf("vec%0d.busy", i),  busy,          vecs[i].exp[2]);
            check($sformatf("vec%0d.ready", i), cfg.cfg_ready, vecs[i].exp[1]);
            check($sformatf("vec%0d.err", i),   cfg.cfg_err,   vecs[i].exp[0]);
        end

        // Ratio 5: drop enable mid-high phase, out finishes its period then IDLE
        rst = 1'b1; enable = 1'b0; cfg.cfg_valid = 1'b0;
        step();
        rst = 1'b0; cfg.cfg_valid = 1'b1; cfg.cfg_div = 8'd5;
        step();
        cfg.cfg_valid = 1'b0; enable = 1'b1;
        step();
        check("d5.start.busy", busy, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            enable = (c < 8);
            step();
            check($sformatf("d5stop.out c%0d", c),  out,  (c >= 5 && c < 10));
            check($sformatf("d5stop.tick c%0d", c), tick, (c == 5 || c == 10));
            check($sformatf("d5stop.busy c%0d", c), busy, (c < 10));
        end

        // Re-enable inside STOP: waveform must be uninterrupted
        enable = 1'b1;
        step();
        check("d5re.start.out", out, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            enable = !(c == 2 || c == 3);
            step();
            check($sformatf("d5re.out c%0d", c),   out,           ((c / 5) % 2) == 1);
            check($sformatf("d5re.tick c%0d", c),  tick,          (c % 5) == 0);
            check($sformatf("d5re.busy c%0d", c),  busy,          1'b1);
            check($sformatf("d5re.ready c%0d", c), cfg.cfg_ready, !(c == 2 || c == 3));
        end

        // Default ratio, then a ratio change that is wiped out by reset while pending
        rst = 1'b1; enable = 1'b1; cfg.cfg_valid = 1'b0;
        step();
        check("def.rst.out", out, 1'b0);
        check("def.rst.busy", busy, 1'b0);
        rst = 1'b0;
        step();
        check("def.start.busy", busy, 1'b1);
        for (int c = 1; c <= 26; c++) begin
            cfg.cfg_valid = (c == 21);
            cfg.cfg_div   = 8'd9;
            rst           = (c == 26);
            step();
            if (c < 26) begin
                check($sformatf("def.out c%0d", c),  out,  ((c / 16) % 2) == 1);
                check($sformatf("def.tick c%0d", c), tick, (c % 16) == 0);
                check($sformatf("def.busy c%0d", c), busy, 1'b1);
                check($sformatf("def.ready c%0d", c), cfg.cfg_ready, (c < 21));
            end else begin
                check("pendrst.out",   out,           1'b0);
                check("pendrst.tick",  tick,          1'b0);
                check("pendrst.busy",  busy,          1'b0);
                check("pendrst.ready", cfg.cfg_ready, 1'b1);
                check("pendrst.err",   cfg.cfg_err,   1'b0);
            end
        end
        rst = 1'b0; cfg.cfg_valid = 1'b0;
        step();
        check("post.start.out", out, 1'b0);
        for (int c = 1; c <= 34; c++) begin
            step();
            check($sformatf("post.out c%0d", c),  out,  ((c / 16) % 2) == 1);
            check($sformatf("post.tick c%0d", c), tick, (c % 16) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
